// File: rtl/mbm_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mbm_rr_scheduler
//   Shares one combinational 16x16 signed radix-4 Booth multiplier (mbm) among
//   NREQ valid/ready requesters. A round-robin arbiter admits at most one
//   request per cycle into operand stage S1. The product is captured in
//   result stage S2, which drives a single tagged result channel. Both stages
//   stall under result backpressure without dropping or duplicating entries.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   req_valid    [NREQ]       per-requester request valid
//   req_ready    [NREQ]       per-requester accept, one-hot or zero
//   req_a        [NREQ*16]    signed multiplier operands, requester i at [16i+:16]
//   req_b        [NREQ*16]    signed multiplicand operands, same packing
//   res_valid                 result valid
//   res_ready                 downstream accept
//   res_id       [IDW]        requester that issued the result
//   res_product  [32]         signed product a*b
//   busy                      S1 or S2 holds a valid entry
//   op_count     [CNTW]       results handed downstream, wraps modulo 2^CNTW
//
// NREQ must lie in 2..8 and 2^IDW must be at least NREQ.
// -----------------------------------------------------------------------------

// Exact 16x16 signed multiplier using radix-4 Booth recoding: eight partial
// products, each selected from {0, +-m, +-2m}, summed combinationally.
module mbm (
  input  logic signed [15:0] i_multiplier,
  input  logic signed [15:0] i_multiplicand,
  output logic signed [31:0] o_product
);

  logic        [16:0] w_ext;    // multiplier with implicit 0 below the LSB
  logic signed [31:0] w_mcand;  // sign-extended multiplicand
  logic signed [31:0] w_acc;

  // One Booth digit: overlapping bit triplet -> partial product.
  function automatic logic signed [31:0] booth_pp(input logic [2:0] sel,
                                                  input logic signed [31:0] m);
    logic signed [31:0] pp;
    unique case (sel)
      3'b001, 3'b010: pp = m;
      3'b011:         pp = m <<< 1;
      3'b100:         pp = -(m <<< 1);
      3'b101, 3'b110: pp = -m;
      default:        pp = '0;        // 000 and 111
    endcase
    return pp;
  endfunction

  always_comb begin
    // NOTE: every variable written in always_comb gets a value before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    w_ext   = {i_multiplier, 1'b0};
    w_mcand = {{16{i_multiplicand[15]}}, i_multiplicand};
    w_acc   = '0;
    for (int j = 0; j < 8; j++) begin
      w_acc = w_acc + (booth_pp(w_ext[2*j +: 3], w_mcand) << (2*j));
    end
  end

  assign o_product = w_acc;

endmodule

module mbm_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [31:0]          res_product,
  output logic                 busy,
  output logic [CNTW-1:0]      op_count
);

  // Round-robin pointer
  logic [IDW-1:0]      r_rr_ptr;

  // S1: operand stage
  logic                r_s1_valid;
  logic signed [15:0]  r_s1_a;
  logic signed [15:0]  r_s1_b;
  logic [IDW-1:0]      r_s1_id;

  // S2: result stage
  logic                r_s2_valid;
  logic [31:0]         r_s2_product;
  logic [IDW-1:0]      r_s2_id;

  logic [CNTW-1:0]     r_op_count;

  logic                w_s2_adv;
  logic                w_s1_adv;
  logic                w_accept_ok;
  logic                w_any;
  logic [IDW-1:0]      w_gnt;
  logic                w_accept;
  logic [IDW-1:0]      w_nxt_ptr;
  logic signed [15:0]  w_sel_a;
  logic signed [15:0]  w_sel_b;
  logic signed [31:0]  w_product;
  logic                w_res_xfer;

  // (base + k) mod NREQ for the arbiter's wrapping search.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Stall network: S2 can move when empty or draining; S1 can take a new
  // entry when empty or when its current entry moves on this cycle.
  assign w_s2_adv    = !r_s2_valid || res_ready;
  assign w_s1_adv    = r_s1_valid && w_s2_adv;
  assign w_accept_ok = !r_s1_valid || w_s2_adv;
  assign w_res_xfer  = r_s2_valid && res_ready;

  // Arbiter: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_any = 1'b1;
        w_gnt = wrap_add(r_rr_ptr, k);
      end
    end
  end

  // Reset also masks the accept so req_ready stays low while rst is held.
  assign w_accept  = w_any && w_accept_ok && !rst;
  assign req_ready = w_accept ? (NREQ'(1) << w_gnt) : '0;
  assign w_nxt_ptr = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + IDW'(1);

  assign w_sel_a = req_a[16*w_gnt +: 16];
  assign w_sel_b = req_b[16*w_gnt +: 16];

  mbm u_mbm (
    .i_multiplier   (r_s1_a),
    .i_multiplicand (r_s1_b),
    .o_product      (w_product)
  );

  // NOTE: the datapath fields are reset along with the valid bits because
  // res_product and res_id must read 0 during and after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_id      <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_product <= '0;
      r_s2_id      <= '0;
      r_op_count   <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values; S1 can hand its old entry to S2 and load a new one
      // on the same edge.
      if (w_accept) begin
        r_rr_ptr   <= w_nxt_ptr;
        r_s1_valid <= 1'b1;
        r_s1_a     <= w_sel_a;
        r_s1_b     <= w_sel_b;
        r_s1_id    <= w_gnt;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_product <= w_product;
          r_s2_id      <= r_s1_id;
        end
      end

      if (w_res_xfer) begin
        r_op_count <= r_op_count + CNTW'(1);
      end
    end
  end

  assign res_valid   = r_s2_valid;
  assign res_id      = r_s2_id;
  assign res_product = r_s2_product;
  assign busy        = r_s1_valid || r_s2_valid;
  assign op_count    = r_op_count;

endmodule
